dmem_line_responder: RTL and testbench

//  Memory-side responder for the LC-3b pipeline data port: accepts word read/write requests, answers each with a
//  one-cycle mem_resp pulse, and backs them with a single write-back line buffer in front of physical memory.

---
 rtl/lc3b_types.sv | 17 +
 rtl/dmem_line_responder_if.sv | 23 ++
 rtl/dmem_line_datapath.sv | 63 ++++++
 rtl/dmem_line_responder.sv | 137 +++++++++++++
 tb/tb_dmem_line_responder.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b data-port types and the state encoding of the line responder.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;
  typedef logic [11:0]  lc3b_c_tag;
  typedef logic [2:0]   lc3b_c_offset;
  typedef logic [1:0]   lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESPOND,
    ST_WRITEBACK,
    ST_FILL
  } dmem_resp_state_t;

endpackage

// File: rtl/dmem_line_responder_if.sv
// Word-request port between the MEM-stage access control (master) and the line responder (slave).
interface dmem_line_responder_if;
  import lc3b_types::*;

  logic          mem_read;
  logic          mem_write;
  lc3b_mem_wmask mem_byte_enable;
  lc3b_word      mem_address;
  lc3b_word      mem_wdata;
  lc3b_word      mem_rdata;
  logic          mem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/dmem_line_datapath.sv
// Single write-back line buffer: tag/valid/dirty state, word select and byte-masked merge.
module dmem_line_datapath #(
  parameter int TAG_W = 12,
  parameter int IDX_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic [IDX_W-1:0]         req_idx,
  input  logic [15:0]              wdata,
  input  logic [1:0]               byte_enable,
  input  logic                     merge_en,
  input  logic                     clear_dirty,
  input  logic                     fill_load,
  input  logic [TAG_W-1:0]         fill_tag,
  input  logic [(16 << IDX_W)-1:0] fill_line,
  output logic                     line_valid,
  output logic                     line_dirty,
  output logic [TAG_W-1:0]         line_tag,
  output logic [(16 << IDX_W)-1:0] line_data,
  output logic                     hit,
  output logic [15:0]              sel_word
);

  localparam int LINE_W = 16 << IDX_W;

  logic [IDX_W+3:0]  word_base;
  logic [IDX_W+3:0]  high_byte_base;
  logic [LINE_W-1:0] merged_line;

  assign word_base      = {req_idx, 4'b0000};
  assign high_byte_base = {req_idx, 4'b1000};
  assign hit            = line_valid && (line_tag == req_tag);
  assign sel_word       = line_data[word_base +: 16];

  always_comb begin
    merged_line = line_data;
    if (byte_enable[0]) merged_line[word_base +: 8]      = wdata[7:0];
    if (byte_enable[1]) merged_line[high_byte_base +: 8] = wdata[15:8];
  end

  // A fill always wins: the FSM never merges and fills in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid <= 1'b0;
      line_dirty <= 1'b0;
      line_tag   <= '0;
      line_data  <= '0;
    end else if (fill_load) begin
      line_valid <= 1'b1;
      line_dirty <= 1'b0;
      line_tag   <= fill_tag;
      line_data  <= fill_line;
    end else begin
      if (clear_dirty) line_dirty <= 1'b0;
      if (merge_en && (byte_enable != 2'b00)) begin
        line_data  <= merged_line;
        line_dirty <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_line_responder.sv
// LC-3b data-port responder backed by one write-back line buffer in front of pmem.
// Define DMEM_HIT_FASTPATH_EN to answer IDLE hits combinationally (0-cycle hit latency).
module dmem_line_responder
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int OFFSET_BITS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  dmem_line_responder_if.slave           mem,
  output logic                           pmem_read,
  output logic                           pmem_write,
  output logic [ADDR_WIDTH-1:0]          pmem_address,
  output logic [(8 << OFFSET_BITS)-1:0]  pmem_wdata,
  input  logic [(8 << OFFSET_BITS)-1:0]  pmem_rdata,
  input  logic                           pmem_resp
);

  localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS;
  localparam int IDX_W = OFFSET_BITS - 1;

  dmem_resp_state_t state, next_state;

  logic [TAG_W-1:0]              req_tag;
  logic [TAG_W-1:0]              miss_tag;
  logic [TAG_W-1:0]              line_tag;
  logic [IDX_W-1:0]              req_idx;
  logic [(8 << OFFSET_BITS)-1:0] line_data;
  logic [15:0]                   sel_word;
  logic                          line_valid;
  logic                          line_dirty;
  logic                          hit;
  logic                          request;
  logic                          merge_en;
  logic                          clear_dirty;
  logic                          fill_load;
  logic                          capture_miss;
  logic                          addr_lsb_unused;

  assign req_tag         = mem.mem_address[ADDR_WIDTH-1:OFFSET_BITS];
  assign req_idx         = mem.mem_address[OFFSET_BITS-1:1];
  assign addr_lsb_unused = mem.mem_address[0];
  assign request         = mem.mem_read | mem.mem_write;
  assign pmem_wdata      = line_data;

  dmem_line_datapath #(
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .req_tag     (req_tag),
    .req_idx     (req_idx),
    .wdata       (mem.mem_wdata),
    .byte_enable (mem.mem_byte_enable),
    .merge_en    (merge_en),
    .clear_dirty (clear_dirty),
    .fill_load   (fill_load),
    .fill_tag    (miss_tag),
    .fill_line   (pmem_rdata),
    .line_valid  (line_valid),
    .line_dirty  (line_dirty),
    .line_tag    (line_tag),
    .line_data   (line_data),
    .hit         (hit),
    .sel_word    (sel_word)
  );

  // The miss tag is latched so the fill completes even if the request is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      miss_tag <= '0;
    end else begin
      state <= next_state;
      if (capture_miss) miss_tag <= req_tag;
    end
  end

  always_comb begin
    next_state    = state;
    mem.mem_resp  = 1'b0;
    mem.mem_rdata = '0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_address  = '0;
    merge_en      = 1'b0;
    clear_dirty   = 1'b0;
    fill_load     = 1'b0;
    capture_miss  = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (request) begin
          if (hit) begin
`ifdef DMEM_HIT_FASTPATH_EN
            mem.mem_resp = 1'b1;
            merge_en     = mem.mem_write;
`else
            next_state   = ST_RESPOND;
`endif
          end else begin
            capture_miss = 1'b1;
            next_state   = (line_valid && line_dirty) ? ST_WRITEBACK : ST_FILL;
          end
        end
      end
      ST_RESPOND: begin
        mem.mem_resp = 1'b1;
        merge_en     = mem.mem_write;
        next_state   = ST_IDLE;
      end
      ST_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {line_tag, {OFFSET_BITS{1'b0}}};
        if (pmem_resp) begin
          clear_dirty = 1'b1;
          next_state  = ST_FILL;
        end
      end
      ST_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag, {OFFSET_BITS{1'b0}}};
        if (pmem_resp) begin
          fill_load  = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase

    // Read data is only meaningful alongside the response pulse.
    if (mem.mem_resp) mem.mem_rdata = sel_word;
  end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed and random requests against a flat-memory-plus-buffer reference, with a delayed pmem model.
module tb_dmem_line_responder;
  import lc3b_types::*;

`ifdef DMEM_HIT_FASTPATH_EN
  localparam int HIT_LAT    = 0;
  localparam int MISS_EXTRA = 1;
`else
  localparam int HIT_LAT    = 1;
  localparam int MISS_EXTRA = 2;
`endif

  logic         clk;
  logic         rst;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  dmem_line_responder_if ifc ();

  dmem_line_responder dut (
    .clk          (clk),
    .rst          (rst),
    .mem          (ifc.slave),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total;
  int bad;
  logic [15:0] seedWord;
  int pmemDelay;

  // pmem model state, written only by the pmem process below
  logic [127:0] backing [logic [15:0]];
  bit           opWr [$];
  logic [15:0]  opAddr [$];
  logic [127:0] opData [$];
  int           glitchCount;
  int           respDuringPmem;
  bit           busy;
  int           waitLeft;
  logic [15:0]  heldAddr;

  // reference model: committed memory plus the buffered line
  logic [15:0] committed [logic [15:0]];
  logic        mValid;
  logic        mDirty;
  logic [11:0] mTag;
  logic [15:0] mWords [8];

  function automatic logic [15:0] initWord(input logic [15:0] a);
    logic [15:0] h;
    if (a == 16'h1234) return 16'hBEEF;
    h = (a * 16'h9E37) ^ seedWord ^ 16'h5A5A;
    return h;
  endfunction

  function automatic logic [127:0] lineInit(input logic [15:0] base);
    logic [127:0] l;
    for (int i = 0; i < 8; i++) l[16*i +: 16] = initWord(base + 16'(2*i));
    return l;
  endfunction

  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (committed.exists(a)) return committed[a];
    return initWord(a);
  endfunction

  always @(negedge clk) begin
    pmem_resp = 1'b0;
    if (pmem_read || pmem_write) begin
      if (!busy) begin
        busy     = 1'b1;
        heldAddr = pmem_address;
        waitLeft = pmemDelay;
      end else if (pmem_address !== heldAddr) begin
        glitchCount++;
      end
      if (ifc.mem_resp) respDuringPmem++;
      if (waitLeft == 0) begin
        pmem_resp = 1'b1;
        busy      = 1'b0;
        if (pmem_write) begin
          backing[pmem_address] = pmem_wdata;
          opWr.push_back(1'b1);
          opData.push_back(pmem_wdata);
        end else begin
          if (!backing.exists(pmem_address)) backing[pmem_address] = lineInit(pmem_address);
          pmem_rdata = backing[pmem_address];
          opWr.push_back(1'b0);
          opData.push_back(pmem_rdata);
        end
        opAddr.push_back(pmem_address);
      end else begin
        waitLeft--;
      end
    end else begin
      busy = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [15:0] wd, input logic [1:0] be, input int delay,
                               output logic [15:0] rdataOut);
    logic [11:0]  rtag;
    logic [11:0]  oldTag;
    logic         hit;
    logic         expWb;
    logic         got;
    logic [127:0] expWbLine;
    logic [15:0]  expRd;
    logic [15:0]  w;
    int idx, expLat, lat, n0, expOps;
    rtag      = addr[15:4];
    idx       = int'(addr[3:1]);
    oldTag    = mTag;
    hit       = mValid && (mTag == rtag);
    expWb     = !hit && mValid && mDirty;
    expWbLine = '0;
    expRd     = '0;
    if (!hit) begin
      if (expWb) begin
        for (int i = 0; i < 8; i++) begin
          expWbLine[16*i +: 16] = mWords[i];
          committed[{mTag, 4'h0} + 16'(2*i)] = mWords[i];
        end
      end
      for (int i = 0; i < 8; i++) mWords[i] = memWord({rtag, 4'h0} + 16'(2*i));
      mValid = 1'b1;
      mDirty = 1'b0;
      mTag   = rtag;
    end
    if (wr) begin
      w = mWords[idx];
      if (be[0]) w[7:0]  = wd[7:0];
      if (be[1]) w[15:8] = wd[15:8];
      mWords[idx] = w;
      if (be != 2'b00) mDirty = 1'b1;
    end else begin
      expRd = mWords[idx];
    end
    expOps = hit ? 0 : (expWb ? 2 : 1);
    expLat = hit ? HIT_LAT : ((expWb ? delay + 1 : 0) + delay + 1 + MISS_EXTRA);

    pmemDelay = delay;
    n0 = opWr.size();
    @(posedge clk); #1;
    ifc.mem_read        = rd;
    ifc.mem_write       = wr;
    ifc.mem_address     = addr;
    ifc.mem_wdata       = wd;
    ifc.mem_byte_enable = be;
    got = 1'b0;
    lat = 0;
    rdataOut = '0;
    while (!got && lat < 200) begin
      @(negedge clk);
      if (ifc.mem_resp) begin
        got = 1'b1;
        rdataOut = ifc.mem_rdata;
      end else begin
        lat++;
      end
    end
    @(posedge clk); #1;
    ifc.mem_read  = 1'b0;
    ifc.mem_write = 1'b0;
    @(negedge clk);
    checkOutput("resp_single", ifc.mem_resp, 1'b0);
    checkOutput("resp_seen", got, 1'b1);
    checkOutput("latency", lat, expLat);
    if (!wr) checkOutput("rdata", rdataOut, expRd);
    checkOutput("pmem_ops", opWr.size() - n0, expOps);
    if ((opWr.size() - n0 == expOps) && (expOps > 0)) begin
      if (expWb) begin
        checkOutput("wb_kind", opWr[n0], 1'b1);
        checkOutput("wb_addr", opAddr[n0], {oldTag, 4'h0});
        checkOutput("wb_data", opData[n0], expWbLine);
      end
      checkOutput("fill_kind", opWr[n0 + expOps - 1], 1'b0);
      checkOutput("fill_addr", opAddr[n0 + expOps - 1], {rtag, 4'h0});
    end
  endtask

  initial begin
    logic [15:0] rdv;
    logic [15:0] origWord;
    logic [15:0] base;
    logic [31:0] r;
    logic        seen;
    int          opBefore;
    int          glitchBefore;
    int          kind;

    total = 0;
    bad = 0;
    seedWord = 16'($urandom);
    pmemDelay = 0;
    glitchCount = 0;
    respDuringPmem = 0;
    busy = 1'b0;
    waitLeft = 0;
    mValid = 1'b0;
    mDirty = 1'b0;
    mTag = '0;
    for (int i = 0; i < 8; i++) mWords[i] = '0;
    rst = 1'b1;
    ifc.mem_read = 1'b0;
    ifc.mem_write = 1'b0;
    ifc.mem_address = '0;
    ifc.mem_wdata = '0;
    ifc.mem_byte_enable = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_resp", ifc.mem_resp, 1'b0);
    checkOutput("rst_mem_rdata", ifc.mem_rdata, 16'h0);
    checkOutput("rst_pmem_read", pmem_read, 1'b0);
    checkOutput("rst_pmem_write", pmem_write, 1'b0);
    checkOutput("rst_pmem_address", pmem_address, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] step 1: clean-miss read of 0x1234");
    applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, 3, rdv);
    checkOutput("t1_beef", rdv, 16'hBEEF);

    $display("[TB] step 2: low-byte write then read of 0x1236");
    origWord = initWord(16'h1236);
    applyStimulus(1'b0, 1'b1, 16'h1236, 16'hA55A, 2'b01, 0, rdv);
    applyStimulus(1'b1, 1'b0, 16'h1236, 16'h0, 2'b00, 0, rdv);
    checkOutput("t2_merge", rdv, {origWord[15:8], 8'h5A});

    $display("[TB] step 3: dirty miss to 0x4000");
    applyStimulus(1'b1, 1'b0, 16'h4000, 16'h0, 2'b00, 2, rdv);

    $display("[TB] step 4: slow fill of 0x1230");
    glitchBefore = glitchCount;
    applyStimulus(1'b1, 1'b0, 16'h1230, 16'h0, 2'b00, 20, rdv);
    checkOutput("t4_addr_stable", glitchCount - glitchBefore, 0);

    $display("[TB] step 5: reset during write-back");
    applyStimulus(1'b0, 1'b1, 16'h1232, 16'h1111, 2'b11, 0, rdv);
    opBefore = opWr.size();
    pmemDelay = 10;
    @(posedge clk); #1;
    ifc.mem_read = 1'b1;
    ifc.mem_address = 16'h4000;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (pmem_write) seen = 1'b1;
    end
    checkOutput("t5_wb_started", seen, 1'b1);
    checkOutput("t5_wb_addr", pmem_address, 16'h1230);
    @(negedge clk);
    rst = 1'b1;
    ifc.mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_pmem_write_drop", pmem_write, 1'b0);
    checkOutput("t5_pmem_read_idle", pmem_read, 1'b0);
    checkOutput("t5_no_resp", ifc.mem_resp, 1'b0);
    checkOutput("t5_no_wb_logged", opWr.size() - opBefore, 0);
    mValid = 1'b0;
    mDirty = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h1232, 16'h0, 2'b00, 2, rdv);

    $display("[TB] step 6: hit latency on 0x1230");
    applyStimulus(1'b1, 1'b0, 16'h1230, 16'h0, 2'b00, 0, rdv);

    $display("[TB] random phase");
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      r = $urandom;
      case (kind)
        0: base = 16'h1230;
        1: base = 16'h4000;
        2: base = 16'hBEE0;
        default: base = {r[15:4], 4'h0};
      endcase
      base = base + 16'(2 * $urandom_range(0, 7)) + 16'($urandom_range(0, 1));
      kind = $urandom_range(0, 2);
      applyStimulus(kind != 1, kind != 0, base, 16'($urandom), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 3), rdv);
    end

    checkOutput("pmem_addr_glitches", glitchCount, 0);
    checkOutput("resp_during_pmem", respDuringPmem, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
